// File: rtl/sdp_stream_ctrl_if.sv
// Stream and SRAM-port bundle for sdp_stream_ctrl.
// The master modport is the controller side; slave is the source/sink/SRAM side.
interface sdp_stream_ctrl_if #(
  parameter int WIDTH = 768,
  parameter int DEPTH = 2048
);
  localparam int BITS_DEPTH = $clog2(DEPTH);
  localparam int BITS_LEVEL = $clog2(DEPTH + 4);

  logic                  s_valid;
  logic                  s_ready;
  logic [WIDTH-1:0]      s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [WIDTH-1:0]      m_data;
  logic                  sram_ena;
  logic                  sram_wea;
  logic [BITS_DEPTH-1:0] sram_addra;
  logic [WIDTH-1:0]      sram_dina;
  logic                  sram_enb;
  logic [BITS_DEPTH-1:0] sram_addrb;
  logic [WIDTH-1:0]      sram_doutb;
  logic [BITS_LEVEL-1:0] level;

  modport master (
    input  s_valid, s_data, m_ready, sram_doutb,
    output s_ready, m_valid, m_data, sram_ena, sram_wea, sram_addra, sram_dina,
           sram_enb, sram_addrb, level
  );

  modport slave (
    output s_valid, s_data, m_ready, sram_doutb,
    input  s_ready, m_valid, m_data, sram_ena, sram_wea, sram_addra, sram_dina,
           sram_enb, sram_addrb, level
  );
endinterface

// File: rtl/sdp_stream_ctrl.sv
// Circular-buffer FIFO controller around a simple dual-port SRAM; a 3-entry
// output buffer hides the 1-cycle SRAM read latency so the stream runs at full rate.
module sdp_stream_ctrl #(
  parameter int WIDTH = 768,
  parameter int DEPTH = 2048
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  sdp_stream_ctrl_if.master    bus
);
  localparam int BITS_DEPTH = $clog2(DEPTH);
  localparam int BITS_LEVEL = $clog2(DEPTH + 4);
  localparam logic [BITS_DEPTH-1:0] L_PTR_LAST = BITS_DEPTH'(DEPTH - 1);
  localparam logic [BITS_DEPTH-1:0] L_PTR_ONE  = BITS_DEPTH'(1);
  localparam logic [BITS_LEVEL-1:0] L_DEPTH    = BITS_LEVEL'(DEPTH);
  localparam logic [BITS_LEVEL-1:0] L_CNT_ONE  = BITS_LEVEL'(1);

  logic [BITS_DEPTH-1:0] r_wptr, r_rptr;
  logic [BITS_LEVEL-1:0] r_cnt;
  logic                  r_inflight;
  logic [WIDTH-1:0]      r_obuf [3];
  logic [1:0]            r_ohead, r_ocnt;
  logic                  r_s_ready;

  logic                  w_push, w_issue, w_pop;
  logic [2:0]            w_occ, w_tail_sum;
  logic [1:0]            w_tail, w_ohead_next, w_ocnt_next;
  logic [BITS_LEVEL-1:0] w_cnt_next;
  logic [BITS_DEPTH-1:0] w_wptr_next, w_rptr_next;

  assign w_push     = bus.s_valid & r_s_ready;
  assign w_occ      = {1'b0, r_ocnt} + {2'b00, r_inflight};
  // Issue looks only at registered state so m_ready never reaches the SRAM read port.
  assign w_issue    = (r_cnt != '0) && (w_occ < 3'd3);
  assign w_pop      = (r_ocnt != 2'd0) & bus.m_ready;
  assign w_tail_sum = {1'b0, r_ohead} + {1'b0, r_ocnt};
  assign w_tail     = (w_tail_sum >= 3'd3) ? 2'(w_tail_sum - 3'd3) : w_tail_sum[1:0];

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_push && !w_issue)
      w_cnt_next = r_cnt + L_CNT_ONE;
    else if (w_issue && !w_push)
      w_cnt_next = r_cnt - L_CNT_ONE;

    w_ocnt_next = r_ocnt;
    if (r_inflight && !w_pop)
      w_ocnt_next = r_ocnt + 2'd1;
    else if (!r_inflight && w_pop)
      w_ocnt_next = r_ocnt - 2'd1;

    w_ohead_next = r_ohead;
    if (w_pop)
      w_ohead_next = (r_ohead == 2'd2) ? 2'd0 : r_ohead + 2'd1;

    w_wptr_next = r_wptr;
    if (w_push)
      w_wptr_next = (r_wptr == L_PTR_LAST) ? '0 : r_wptr + L_PTR_ONE;

    w_rptr_next = r_rptr;
    if (w_issue)
      w_rptr_next = (r_rptr == L_PTR_LAST) ? '0 : r_rptr + L_PTR_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_ohead    <= 2'd0;
      r_ocnt     <= 2'd0;
      r_s_ready  <= 1'b0;
    end else if (clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_ohead    <= 2'd0;
      r_ocnt     <= 2'd0;
      r_s_ready  <= 1'b1;
    end else begin
      r_wptr     <= w_wptr_next;
      r_rptr     <= w_rptr_next;
      r_cnt      <= w_cnt_next;
      r_inflight <= w_issue;
      r_ohead    <= w_ohead_next;
      r_ocnt     <= w_ocnt_next;
      r_s_ready  <= (w_cnt_next < L_DEPTH);
    end
  end

  // Data storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (r_inflight && !clear)
      r_obuf[w_tail] <= bus.sram_doutb;
  end

  assign bus.s_ready    = r_s_ready;
  assign bus.m_valid    = (r_ocnt != 2'd0);
  assign bus.m_data     = r_obuf[r_ohead];
  assign bus.sram_ena   = w_push;
  assign bus.sram_wea   = w_push;
  assign bus.sram_addra = r_wptr;
  assign bus.sram_dina  = bus.s_data;
  assign bus.sram_enb   = w_issue;
  assign bus.sram_addrb = r_rptr;
  assign bus.level      = r_cnt + BITS_LEVEL'(r_inflight) + BITS_LEVEL'(r_ocnt);
endmodule

// File: tb/tb_sdp_stream_ctrl.sv
// Randomized and directed bench for sdp_stream_ctrl with a behavioural SRAM and
// a queue-based reference FIFO that tracks every accepted and delivered word.
module tb_sdp_stream_ctrl;
  localparam int W = 16;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  sdp_stream_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sdp_stream_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .bus   (bus)
  );

  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (bus.sram_ena && bus.sram_wea) mem[bus.sram_addra] <= bus.sram_dina;
    if (bus.sram_enb) bus.sram_doutb <= mem[bus.sram_addrb];
  end

  int errors = 0;
  int checks = 0;

  // Reference FIFO: words accepted and not yet delivered, oldest first.
  logic [W-1:0] q [$];
  bit           mp_push, mp_pop, mp_clr, mp_hold;
  logic [W-1:0] mp_sdata, mp_hold_data, exp_head;

  always begin
    @(negedge clk);
    if (!rstn) begin
      q.delete();
      mp_push = 0; mp_pop = 0; mp_clr = 0; mp_hold = 0;
    end else begin
      checks++;
      if (int'(bus.level) != q.size()) begin
        errors++;
        $display("FAIL model_level: got %0d want %0d", bus.level, q.size());
      end
      if (bus.m_valid === 1'b1) begin
        checks++;
        exp_head = (q.size() > 0) ? q[0] : 'x;
        if (q.size() == 0 || bus.m_data !== exp_head) begin
          errors++;
          $display("FAIL model_order: got %0h want %0h (stored %0d)", bus.m_data, exp_head, q.size());
        end
      end
      if (mp_hold) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== mp_hold_data) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b d=%0h want v=1 d=%0h", bus.m_valid, bus.m_data, mp_hold_data);
        end
      end
      mp_push      = ((bus.s_valid & bus.s_ready) === 1'b1);
      mp_sdata     = bus.s_data;
      mp_pop       = ((bus.m_valid & bus.m_ready) === 1'b1);
      mp_clr       = (clear === 1'b1);
      mp_hold      = ((bus.m_valid & ~bus.m_ready & ~clear) === 1'b1);
      mp_hold_data = bus.m_data;
    end
    @(posedge clk);
    if (rstn) begin
      if (mp_pop && q.size() > 0) void'(q.pop_front());
      if (mp_push) q.push_back(mp_sdata);
      if (mp_clr) q.delete();
    end
  end

  task automatic pulse_clear();
    bus.s_valid = 1'b0; bus.m_ready = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; clear = 1'b0; bus.s_valid = 1'b1; bus.s_data = 16'h1234; bus.m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.sram_wea !== 1'b0 ||
          bus.sram_ena !== 1'b0 || bus.sram_enb !== 1'b0 || bus.level !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got rdy=%0b mv=%0b wea=%0b ena=%0b enb=%0b lvl=%0d want all 0",
                 bus.s_ready, bus.m_valid, bus.sram_wea, bus.sram_ena, bus.sram_enb, bus.level);
      end
    end
    @(posedge clk); #1;
    rstn = 1'b1; bus.s_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b want 1", bus.s_ready);
    end
  endtask

  task automatic test_single();
    bus.s_valid = 1'b1; bus.s_data = 16'h00A5; bus.m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sram_wea !== 1'b1 || bus.sram_ena !== 1'b1 || bus.sram_addra !== 4'd0 || bus.sram_dina !== 16'h00A5) begin
      errors++;
      $display("FAIL single_write: got wea=%0b ena=%0b addra=%0d dina=%0h want 1 1 0 a5",
               bus.sram_wea, bus.sram_ena, bus.sram_addra, bus.sram_dina);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sram_enb !== 1'b1 || bus.sram_addrb !== 4'd0 || bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_read_issue: got enb=%0b addrb=%0d mv=%0b want 1 0 0", bus.sram_enb, bus.sram_addrb, bus.m_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: got %0b want 0", bus.m_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'h00A5) begin
      errors++;
      $display("FAIL single_output: got mv=%0b data=%0h want 1 a5", bus.m_valid, bus.m_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.level !== '0 || bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after_pop: got lvl=%0d mv=%0b want 0 0", bus.level, bus.m_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    int  n, k;
    logic acc;
    n = 0; k = 0;
    bus.m_ready = 1'b0; bus.s_valid = 1'b1; bus.s_data = W'(n);
    repeat (30) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk); #1;
      if (acc === 1'b1) n++;
      bus.s_data = W'(n);
    end
    @(negedge clk);
    checks++;
    if (n != D + 3 || int'(bus.level) != D + 3 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got accepted=%0d lvl=%0d rdy=%0b want %0d %0d 0", n, bus.level, bus.s_ready, D + 3, D + 3);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) begin
        checks++;
        if (bus.m_data !== W'(k)) begin
          errors++;
          $display("FAIL fill_drain_order: got %0h want %0h", bus.m_data, k);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (k != D + 3 || bus.level !== '0) begin
      errors++;
      $display("FAIL fill_drain_count: got %0d lvl=%0d want %0d 0", k, bus.level, D + 3);
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_wrap_stream();
    int nin, nout, wexp, rexp, wraps_w, wraps_r, cyc;
    nin = 0; nout = 0; wexp = 0; rexp = 0; wraps_w = 0; wraps_r = 0; cyc = 0;
    pulse_clear();
    while (nout < 100 && cyc < 3000) begin
      bus.s_valid = (nin < 100) && ($urandom_range(0, 1) == 1);
      bus.s_data  = W'(16'h4000 + nin);
      bus.m_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if ((bus.s_valid & bus.s_ready) === 1'b1) begin
        checks++;
        if (int'(bus.sram_addra) != wexp) begin
          errors++;
          $display("FAIL wrap_addra: got %0d want %0d", bus.sram_addra, wexp);
        end
        if (wexp == D - 1) wraps_w++;
        wexp = (wexp + 1) % D;
        nin++;
      end
      if (bus.sram_enb === 1'b1) begin
        checks++;
        if (int'(bus.sram_addrb) != rexp) begin
          errors++;
          $display("FAIL wrap_addrb: got %0d want %0d", bus.sram_addrb, rexp);
        end
        if (rexp == D - 1) wraps_r++;
        rexp = (rexp + 1) % D;
      end
      if ((bus.m_valid & bus.m_ready) === 1'b1) begin
        checks++;
        if (bus.m_data !== W'(16'h4000 + nout)) begin
          errors++;
          $display("FAIL wrap_order: got %0h want %0h", bus.m_data, 16'h4000 + nout);
        end
        nout++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    checks++;
    if (nout != 100 || wraps_w < 1 || wraps_r < 1) begin
      errors++;
      $display("FAIL wrap_complete: got out=%0d wraps_w=%0d wraps_r=%0d want 100 >=1 >=1", nout, wraps_w, wraps_r);
    end
  endtask

  task automatic test_full_rate();
    int n, nout;
    logic acc;
    n = 0; nout = 0;
    pulse_clear();
    bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      bus.s_data = W'(16'h8000 + n);
      @(negedge clk);
      acc = bus.s_ready;
      if (c >= 3) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.level !== 5'd3 || bus.s_ready !== 1'b1) begin
          errors++;
          $display("FAIL rate_steady: cycle %0d got mv=%0b lvl=%0d rdy=%0b want 1 3 1", c, bus.m_valid, bus.level, bus.s_ready);
        end
      end
      if ((bus.m_valid & bus.m_ready) === 1'b1) begin
        checks++;
        if (bus.m_data !== W'(16'h8000 + nout)) begin
          errors++;
          $display("FAIL rate_order: got %0h want %0h", bus.m_data, 16'h8000 + nout);
        end
        nout++;
      end
      @(posedge clk); #1;
      if (acc === 1'b1) n++;
    end
    checks++;
    if (nout != 197) begin
      errors++;
      $display("FAIL rate_count: got %0d want 197", nout);
    end
    bus.s_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    checks++;
    if (bus.level !== '0) begin
      errors++;
      $display("FAIL rate_drain: got lvl=%0d want 0", bus.level);
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_clear();
    bit seen;
    seen = 0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1; bus.s_data = W'(16'h00C0 + i);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.level !== 5'd3 || bus.m_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: got lvl=%0d mv=%0b want 3 1", bus.level, bus.m_valid);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0 || bus.level !== '0 || bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_flush: got mv=%0b lvl=%0d rdy=%0b want 0 0 1", bus.m_valid, bus.level, bus.s_ready);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b1; bus.s_data = 16'h0077; bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (bus.m_data !== 16'h0077) begin
          errors++;
          $display("FAIL clear_next_word: got %0h want 77", bus.m_data);
        end
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL clear_next_timeout: got no output want 77 within 10 cycles");
    end
    bus.m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_wrap_stream();
    test_full_rate();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
